// File: rtl/pipeline_wb_trace_if.sv
// Bundles the writeback tap, capture control and trace read port of pipeline_wb_trace.
// The slave side belongs to the trace block; the master side is the pipeline/debug host.
interface pipeline_wb_trace_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = CYC_W + REG_ADDR_W + DATA_W;

  logic                  arm;
  logic                  stop;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] WriteRegW;
  logic [DATA_W-1:0]     ResultW;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ENT_W-1:0]      rd_data;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic [31:0]           commit_count;
  logic [1:0]            state;

  modport slave (
    input  arm, stop, RegWriteW, WriteRegW, ResultW, rd_ready,
    output rd_valid, rd_data, count, overflow, commit_count, state
  );

  modport master (
    output arm, stop, RegWriteW, WriteRegW, ResultW, rd_ready,
    input  rd_valid, rd_data, count, overflow, commit_count, state
  );
endinterface

// File: rtl/pipeline_wb_trace.sv
// Writeback commit trace: logs {timestamp, dest reg, result} of each register commit
// into a ring buffer drained through a first-word-fall-through valid/ready port.
module pipeline_wb_trace #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 16,
  parameter bit STOP_ON_FULL = 1'b1,
  parameter bit IGNORE_R0    = 1'b1
) (
  input logic                CLK,
  input logic                reset,
  pipeline_wb_trace_if.slave trc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CYC_W + REG_ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [31:0]      r_commit_count;
  logic [CYC_W-1:0] r_ts;
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic w_arm;
  logic w_push;
  logic w_full;
  logic w_rd_valid;
  logic w_pop;
  logic w_write;
  logic w_overwrite;

  assign w_arm      = trc.arm && (r_state != CAPTURE);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_rd_valid = (r_count != '0);
  assign w_pop      = w_rd_valid && trc.rd_ready;
  assign w_push     = (r_state == CAPTURE) && trc.RegWriteW &&
                      !(IGNORE_R0 && (trc.WriteRegW == '0));
  // A full stop-on-full buffer is already DONE, so the guard only matters defensively.
  assign w_write     = w_push && (!w_full || w_pop || !STOP_ON_FULL);
  assign w_overwrite = w_write && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (trc.arm) w_state_nxt = CAPTURE;
      CAPTURE: begin
        if (trc.stop)
          w_state_nxt = DONE;
        else if (STOP_ON_FULL && w_write && !w_pop && (r_count == CNT_W'(DEPTH - 1)))
          w_state_nxt = DONE;
      end
      DONE:    if (trc.arm) w_state_nxt = CAPTURE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control stage: state, pointers, occupancy, sticky flags, timestamp
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_commit_count <= '0;
      r_ts           <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm) begin
        r_wr_ptr       <= '0;
        r_rd_ptr       <= '0;
        r_count        <= '0;
        r_overflow     <= 1'b0;
        r_commit_count <= '0;
        r_ts           <= '0;
      end else begin
        if (r_state == CAPTURE)
          r_ts <= r_ts + 1'b1;
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_commit_count != '1)
            r_commit_count <= r_commit_count + 32'd1;
        end
        if (w_pop || w_overwrite)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_overwrite)
          r_overflow <= 1'b1;
        if (w_write && !w_pop && !w_full)
          r_count <= r_count + 1'b1;
        else if (w_pop && !w_write)
          r_count <= r_count - 1'b1;
      end
    end
  end

  // Data stage: entry storage carries no reset; visibility is governed by r_count
  always_ff @(posedge CLK) begin
    if (w_write)
      r_mem[r_wr_ptr] <= {r_ts, trc.WriteRegW, trc.ResultW};
  end

  assign trc.rd_valid     = w_rd_valid;
  assign trc.rd_data      = w_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign trc.count        = r_count;
  assign trc.overflow     = r_overflow;
  assign trc.commit_count = r_commit_count;
  assign trc.state        = r_state;
endmodule
